// File: rtl/buffet_mem_arbiter.sv
// -----------------------------------------------------------------------------
// buffet_mem_arbiter
//
// Shares one single-port SRAM (1-cycle read latency) between the buffet write
// path and the read-scanner read path. At most one memory operation is granted
// per cycle, chosen round-robin or write-priority (with a starvation guard for
// reads). Read data returns through a 2-entry output buffer, and reads are only
// granted while a buffer slot is guaranteed for the returning word, so
// downstream backpressure never drops data.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   clk_en              0 = hold all state, no grants, enables low
//   write_priority      0 = round-robin, 1 = write-priority + starvation guard
//   wr_addr/wr_data/wr_valid, wr_ready      write request / grant
//   rd_addr/rd_valid, rd_ready              read request / grant
//   rd_data/rd_data_valid, rd_data_ready    read response (output buffer head)
//   addr_to_mem/data_to_mem/wen_to_mem/ren_to_mem   SRAM request
//   data_from_mem       SRAM read data, valid the cycle after ren_to_mem
// -----------------------------------------------------------------------------
module buffet_mem_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  write_priority,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    output logic [DATA_WIDTH-1:0] data_to_mem,
    output logic                  wen_to_mem,
    output logic                  ren_to_mem,
    input  logic [DATA_WIDTH-1:0] data_from_mem
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        FAVOUR_WR = 1'b0,
        FAVOUR_RD = 1'b1
    } rr_side_e;

    // Output buffer: two entries addressed by a head pointer and a count.
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  r_inflight;    // a read was issued last enabled cycle
    rr_side_e              r_rr_ptr;
    logic [STARVE_W-1:0]   r_starve_cnt;

    logic       w_active;
    logic       w_pop;
    logic       w_push;
    logic [1:0] w_occ_after_pop;
    logic [2:0] w_slots_used;
    logic       w_rd_ok;
    logic       w_wr_ok;
    logic       w_gnt_wr;
    logic       w_gnt_rd;

    assign w_active = clk_en & ~rst;
    assign w_pop    = w_active & (r_count != 2'd0) & rd_data_ready;
    assign w_push   = w_active & r_inflight;

    // A slot being popped this cycle is free by the time the word returns, so
    // counting occupancy after the pop sustains one read per cycle while the
    // consumer keeps up, and still never lets a returning word find no room.
    assign w_occ_after_pop = r_count - {1'b0, w_pop};
    assign w_slots_used    = {1'b0, w_occ_after_pop} + {2'b00, r_inflight};
    assign w_rd_ok         = w_active & rd_valid & (w_slots_used < 3'd2);
    assign w_wr_ok         = w_active & wr_valid;

    // NOTE: every always_comb output gets a default on its first line, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_wr = w_wr_ok;
        w_gnt_rd = w_rd_ok;
        if (w_wr_ok && w_rd_ok) begin
            if (write_priority) begin
                w_gnt_rd = (r_starve_cnt == STARVE_MAX);
            end else begin
                w_gnt_rd = (r_rr_ptr == FAVOUR_RD);
            end
            w_gnt_wr = ~w_gnt_rd;
        end
    end

    // SRAM request: purely combinational from the grant, zero when idle.
    always_comb begin
        addr_to_mem = '0;
        data_to_mem = '0;
        wen_to_mem  = 1'b0;
        ren_to_mem  = 1'b0;
        if (w_gnt_wr) begin
            addr_to_mem = wr_addr;
            data_to_mem = wr_data;
            wen_to_mem  = 1'b1;
        end else if (w_gnt_rd) begin
            addr_to_mem = rd_addr;
            ren_to_mem  = 1'b1;
        end
    end

    assign wr_ready      = w_gnt_wr;
    assign rd_ready      = w_gnt_rd;
    assign rd_data_valid = ~rst & (r_count != 2'd0);
    assign rd_data       = rd_data_valid ? r_buf[r_head] : '0;

    // NOTE: the buffer storage has no reset; r_count alone says which entries
    // are meaningful, so clearing the data would only add reset fan-out.
    // The tail is head+count; with count 2 a push only happens alongside a pop,
    // so writing into the head slot being popped is safe.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_head ^ r_count[0]] <= data_from_mem;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= 1'b0;
            r_count      <= 2'd0;
            r_inflight   <= 1'b0;
            r_rr_ptr     <= FAVOUR_WR;
            r_starve_cnt <= '0;
        end else if (clk_en) begin
            r_inflight <= w_gnt_rd;
            r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end

            // Round-robin pointer moves only when both sides competed.
            if (!write_priority && w_wr_ok && w_rd_ok) begin
                r_rr_ptr <= w_gnt_wr ? FAVOUR_RD : FAVOUR_WR;
            end

            // Consecutive cycles an eligible read lost to a write, saturating.
            if (!w_rd_ok || w_gnt_rd) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
